// File: rtl/pc_seq_pkg.sv
// Shared branch-type and sequencer-state encodings for the PC sequencer slice.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_JMP  = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5
   } br_type_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } seq_state_t;

   // Codes 6 and 7 are reserved and behave as a plain increment.
   function automatic br_type_t decode_br(input logic [2:0] raw);
      case (raw)
         3'd1:    return BR_BEQ;
         3'd2:    return BR_BNE;
         3'd3:    return BR_JMP;
         3'd4:    return BR_CALL;
         3'd5:    return BR_RET;
         default: return BR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack used by CALL/RET; overflow and underflow are
// refused here and reported upstream through full/empty.
module ret_stack #(
   parameter int D     = 12,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [D-1:0] din,
   output logic [D-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [D-1:0]  r_mem [DEPTH];
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_top_idx;

   // Index arithmetic wraps in AW bits, so a full stack still points at DEPTH-1.
   assign w_wr_idx  = r_cnt[AW-1:0];
   assign w_top_idx = w_wr_idx - 1'b1;
   assign full      = (r_cnt == CW'(DEPTH));
   assign empty     = (r_cnt == '0);
   assign top       = r_mem[w_top_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (push && !full) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (pop && !empty) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         r_mem[w_wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control with zero-latency PC strobes.
// Return stack for CALL/RET is built only when PC_SEQ_RET_STACK_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int D     = 12,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stall,
   input  logic         halt_req,
   input  logic [2:0]   br_type,
   input  logic         zero_flag,
   input  logic [D-1:0] target_in,
   input  logic [D-1:0] prog_ctr,
   output logic         branch_en,
   output logic         reljump_en,
   output logic         absjump_en,
   output logic [D-1:0] target,
   output logic         done,
   output logic         err
);

   seq_state_t r_state;
   logic       r_done;
   br_type_t   w_br;
   logic       w_active;
   logic       w_stk_err;

   assign w_br     = decode_br(br_type);
   assign w_active = !reset && (r_state == S_RUN) && !stall && !halt_req;
   assign done     = r_done;

`ifdef PC_SEQ_RET_STACK_EN
   logic         r_err;
   logic         w_push;
   logic         w_pop;
   logic [D-1:0] w_top;
   logic         w_full;
   logic         w_empty;

   ret_stack #(
      .D     (D),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (prog_ctr + D'(1)),
      .top   (w_top),
      .full  (w_full),
      .empty (w_empty)
   );

   assign err = r_err;
`else
   logic w_unused_pc;

   assign w_unused_pc = ^prog_ctr;
   assign err         = 1'b0;
`endif

   // The PC has no enable, so "hold" is a relative jump by zero.
   always_comb begin
      branch_en  = 1'b1;
      reljump_en = 1'b1;
      absjump_en = 1'b0;
      target     = '0;
      w_stk_err  = 1'b0;
`ifdef PC_SEQ_RET_STACK_EN
      w_push     = 1'b0;
      w_pop      = 1'b0;
`endif
      if (w_active) begin
         case (w_br)
            BR_BEQ, BR_BNE: begin
               if ((w_br == BR_BEQ) == zero_flag) begin
                  target = target_in;
               end else begin
                  branch_en  = 1'b0;
                  reljump_en = 1'b0;
               end
            end
            BR_JMP: begin
               reljump_en = 1'b0;
               absjump_en = 1'b1;
               target     = target_in;
            end
`ifdef PC_SEQ_RET_STACK_EN
            BR_CALL: begin
               if (w_full) begin
                  w_stk_err = 1'b1;
               end else begin
                  reljump_en = 1'b0;
                  absjump_en = 1'b1;
                  target     = target_in;
                  w_push     = 1'b1;
               end
            end
            BR_RET: begin
               if (w_empty) begin
                  w_stk_err = 1'b1;
               end else begin
                  reljump_en = 1'b0;
                  absjump_en = 1'b1;
                  target     = w_top;
                  w_pop      = 1'b1;
               end
            end
`else
            BR_CALL: begin
               reljump_en = 1'b0;
               absjump_en = 1'b1;
               target     = target_in;
            end
`endif
            default: begin
               branch_en  = 1'b0;
               reljump_en = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
`ifdef PC_SEQ_RET_STACK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_stk_err || (!stall && halt_req)) begin
                  r_state <= S_HALT;
                  r_done  <= 1'b1;
               end
`ifdef PC_SEQ_RET_STACK_EN
               if (w_stk_err) begin
                  r_err <= 1'b1;
               end
`endif
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: hosts the PC register and compares it
// against a next-PC reference model driven by directed and random instructions.
module tb_pc_sequencer;

   localparam int D     = 12;
   localparam int DEPTH = 4;
`ifdef PC_SEQ_RET_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         stall;
   logic         halt_req;
   logic [2:0]   br_type;
   logic         zero_flag;
   logic [D-1:0] target_in;
   logic [D-1:0] pc;
   logic         branch_en;
   logic         reljump_en;
   logic         absjump_en;
   logic [D-1:0] target;
   logic         done;
   logic         err;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [D-1:0] m_pc;
   bit           m_run;
   bit           m_halt;
   bit           m_err;
   logic [D-1:0] m_stk[$];

   pc_sequencer #(
      .D     (D),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stall      (stall),
      .halt_req   (halt_req),
      .br_type    (br_type),
      .zero_flag  (zero_flag),
      .target_in  (target_in),
      .prog_ctr   (pc),
      .branch_en  (branch_en),
      .reljump_en (reljump_en),
      .absjump_en (absjump_en),
      .target     (target),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // External PC register that consumes the strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             pc <= '0;
      else if (!branch_en)   pc <= pc + 1'b1;
      else if (reljump_en)   pc <= pc + target;
      else if (absjump_en)   pc <= target;
   end

   task automatic drive(input bit st, input bit sl, input bit hr,
                        input logic [2:0] bt, input bit z, input logic [D-1:0] tg);
      @(negedge clk);
      start = st; stall = sl; halt_req = hr; br_type = bt; zero_flag = z; target_in = tg;
   endtask

   task automatic model_apply(input bit st, input bit sl, input bit hr,
                              input logic [2:0] bt, input bit z, input logic [D-1:0] tg);
      if (!m_run) begin
         if (st) m_run = 1'b1;
      end else if (m_halt || sl) begin
         m_pc = m_pc;
      end else if (hr) begin
         m_halt = 1'b1;
      end else begin
         case (bt)
            3'd1: m_pc = z  ? m_pc + tg : m_pc + 1'b1;
            3'd2: m_pc = !z ? m_pc + tg : m_pc + 1'b1;
            3'd3: m_pc = tg;
            3'd4: begin
               if (!STK) m_pc = tg;
               else if (m_stk.size() == DEPTH) begin m_err = 1'b1; m_halt = 1'b1; end
               else begin m_stk.push_back(m_pc + 1'b1); m_pc = tg; end
            end
            3'd5: begin
               if (!STK) m_pc = m_pc + 1'b1;
               else if (m_stk.size() == 0) begin m_err = 1'b1; m_halt = 1'b1; end
               else m_pc = m_stk.pop_back();
            end
            default: m_pc = m_pc + 1'b1;
         endcase
      end
   endtask

   task automatic step(input bit st, input bit sl, input bit hr,
                       input logic [2:0] bt, input bit z, input logic [D-1:0] tg);
      drive(st, sl, hr, bt, z, tg);
      model_apply(st, sl, hr, bt, z, tg);
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0; stall = 1'b0; halt_req = 1'b0; br_type = 3'd0; zero_flag = 1'b0; target_in = '0;
      m_pc = '0; m_run = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_stk.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic restart();
      hard_reset();
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0; stall = 1'b0; halt_req = 1'b0; zero_flag = 1'b1;
      br_type = 3'd3; target_in = 12'h5A5;
      #12;
      total++;
      if ({branch_en, reljump_en, absjump_en} !== 3'b110 || target !== '0) begin
         bad++;
         $display("FAIL reset_hold strobes=%b target=%0h want strobes=110 target=0",
                  {branch_en, reljump_en, absjump_en}, target);
      end
      total++;
      if (done !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL reset_flags done=%b err=%b want 0 0", done, err);
      end
      hard_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
         total++;
         if (pc !== '0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_hold cyc=%0d pc=%0h done=%b want pc=0 done=0", i, pc, done);
         end
      end
   endtask

   task automatic test_fetch_stall();
      restart();
      total++;
      if (pc !== 12'd0) begin bad++; $display("FAIL start_pc pc=%0h want 0", pc); end
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
         total++;
         if (pc !== D'(i)) begin bad++; $display("FAIL fetch_seq pc=%0h want %0h", pc, i); end
      end
      // Stall outranks a pending halt and jump.
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 12'h0AA);
         total++;
         if (pc !== 12'd3 || done !== 1'b0) begin
            bad++; $display("FAIL stall_hold pc=%0h done=%b want pc=3 done=0", pc, done);
         end
      end
      step(1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 12'h0AA);
      total++;
      if (pc !== 12'd4) begin bad++; $display("FAIL stall_resume pc=%0h want 4", pc); end
   endtask

   task automatic test_branch();
      restart();
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'd10);
      step(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 12'hFFE);
      total++;
      if (pc !== 12'd8) begin bad++; $display("FAIL beq_taken pc=%0h want 8", pc); end
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'd10);
      step(1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 12'hFFE);
      total++;
      if (pc !== 12'd11) begin bad++; $display("FAIL beq_not_taken pc=%0h want b", pc); end
      step(1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 12'd5);
      total++;
      if (pc !== 12'd16) begin bad++; $display("FAIL bne_taken pc=%0h want 10", pc); end
      step(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 12'd5);
      total++;
      if (pc !== 12'd17) begin bad++; $display("FAIL bne_not_taken pc=%0h want 11", pc); end
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'd1);
      step(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 12'hFFD);
      total++;
      if (pc !== 12'hFFE) begin bad++; $display("FAIL rel_wrap pc=%0h want ffe", pc); end
   endtask

   task automatic test_call_ret();
      restart();
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'd5);
      step(1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 12'h100);
      total++;
      if (pc !== 12'h100) begin bad++; $display("FAIL call_pc pc=%0h want 100", pc); end
      step(1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 12'h3C3);
      total++;
      if (pc !== (STK ? 12'd6 : 12'h101)) begin
         bad++; $display("FAIL ret_pc pc=%0h want %0h", pc, STK ? 12'd6 : 12'h101);
      end
      // A further RET probes that the stack is empty again.
      step(1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 12'h3C3);
      total++;
      if (err !== STK || done !== STK || pc !== (STK ? 12'd6 : 12'h102)) begin
         bad++; $display("FAIL ret_empty err=%b done=%b pc=%0h want err=%b done=%b", err, done, pc, STK, STK);
      end
   endtask

   task automatic test_overflow();
      restart();
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 3'd4, 1'b0, D'(16 * i));
      total++;
      if (pc !== (STK ? 12'h40 : 12'h50) || err !== STK || done !== STK) begin
         bad++; $display("FAIL call_overflow pc=%0h err=%b done=%b want pc=%0h err=%b done=%b",
                         pc, err, done, STK ? 12'h40 : 12'h50, STK, STK);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'h777);
      total++;
      if (STK && (pc !== 12'h40 || done !== 1'b1 || err !== 1'b1)) begin
         bad++; $display("FAIL overflow_sticky pc=%0h done=%b err=%b want 40 1 1", pc, done, err);
      end else if (!STK && pc !== 12'h777) begin
         bad++; $display("FAIL call_as_jmp pc=%0h want 777", pc);
      end
      hard_reset();
      #1;
      total++;
      if (err !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_clears err=%b done=%b want 0 0", err, done);
      end
   endtask

   task automatic test_halt();
      restart();
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'd20);
      step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 12'd99);
      total++;
      if (done !== 1'b1 || pc !== 12'd20) begin
         bad++; $display("FAIL halt_entry done=%b pc=%0h want 1 14", done, pc);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom));
         total++;
         if (done !== 1'b1 || pc !== 12'd20) begin
            bad++; $display("FAIL halt_frozen done=%b pc=%0h want 1 14", done, pc);
         end
      end
   endtask

   task automatic test_reset_in_run();
      restart();
      step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'h123);
      drive(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 12'h055);
      reset = 1'b1;
      #1;
      total++;
      if ({branch_en, reljump_en, absjump_en} !== 3'b110 || target !== '0) begin
         bad++; $display("FAIL reset_abandons strobes=%b target=%0h want 110 0",
                         {branch_en, reljump_en, absjump_en}, target);
      end
      hard_reset();
   endtask

   task automatic test_random();
      logic [2:0]   bt;
      bit           st, sl, hr, z;
      logic [D-1:0] tg;
      restart();
      for (int n = 0; n < 600; n++) begin
         if (m_halt && ($urandom_range(0, 3) == 0)) restart();
         st = 1'b0;
         sl = ($urandom_range(0, 5) == 0);
         hr = ($urandom_range(0, 60) == 0);
         bt = 3'($urandom_range(0, 7));
         z  = 1'($urandom);
         tg = 12'($urandom);
         drive(st, sl, hr, bt, z, tg);
         #1;
         total++;
         if ((reljump_en && absjump_en) || ((reljump_en || absjump_en) && !branch_en)) begin
            bad++; $display("FAIL strobe_legal n=%0d strobes=%b", n, {branch_en, reljump_en, absjump_en});
         end
         model_apply(st, sl, hr, bt, z, tg);
         @(posedge clk);
         #1;
         total++;
         if (pc !== m_pc || done !== m_halt || err !== m_err) begin
            bad++; $display("FAIL random n=%0d bt=%0d pc=%0h done=%b err=%b want pc=%0h done=%b err=%b",
                            n, bt, pc, done, err, m_pc, m_halt, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_stall();
      test_branch();
      test_call_ret();
      test_overflow();
      test_halt();
      test_reset_in_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, meaning program-counter and target width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning return-stack entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port stall  input  1  hold PC this cycle.
REQ-007 SHALL have port halt_req  input  1  current instruction is the terminal instruction.
REQ-008 SHALL have port br_type  input  3  decoded branch type: NONE=0, BEQ=1, BNE=2, JMP=3, CALL=4, RET=5; 6-7 are treated as NONE.
REQ-009 SHALL have port zero_flag  input  1  ALU zero flag for the current instruction.
REQ-010 SHALL have port target_in  input  D  branch offset (BEQ/BNE, two's complement) or absolute address (JMP/CALL).
REQ-011 SHALL have port prog_ctr  input  D  current PC value from the PC register.
REQ-012 SHALL have ports branch_en, reljump_en, absjump_en  output  1 each  PC control strobes.
REQ-013 SHALL have port target  output  D  jump amount or address to the PC.
REQ-014 SHALL have ports done and err  output  1 each  halted flag and sticky stack-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and HALT; transitions are IDLE->RUN on start=1, RUN->HALT on halt_req=1 (when stall=0) or on a stack error, and HALT persists until reset.
REQ-016 SHALL drive all outputs combinationally from state, inputs and stack top, so the PC acts on them at the same clock edge (zero latency).
REQ-017 SHALL encode "hold" as branch_en=1, reljump_en=1, absjump_en=0, target=0, because the PC has no enable.
REQ-018 SHALL hold in IDLE, HALT, RUN with stall=1, and RUN with halt_req=1.
REQ-019 SHALL use priority stall > halt_req > br_type in RUN; a stalled cycle performs no stack push or pop and no state change.
REQ-020 SHALL, in RUN, issue a relative jump by target_in for BEQ with zero_flag=1 and for BNE with zero_flag=0; otherwise branch_en=0 (PC increments).
REQ-021 SHALL, for JMP, drive branch_en=1, absjump_en=1, reljump_en=0, target=target_in.
REQ-022 SHALL, for CALL, jump absolute to target_in and push prog_ctr+1 (mod 2^D).
REQ-023 SHALL, for RET, jump absolute to the stack top and pop it.
REQ-024 SHALL, on CALL with the stack full or RET with it empty, perform no push or pop, hold the PC, set err, and enter HALT.
REQ-025 SHALL assert reljump_en and absjump_en only with branch_en=1, and never both at once.
REQ-026 SHALL let relative targets wrap modulo 2^D in the PC; the sequencer performs no range check.
REQ-027 SHALL assert done=1 exactly while in HALT.

Reset
REQ-028 SHALL, on reset, enter IDLE, empty the stack (count=0), and clear err and done.
REQ-029 SHALL, while reset is asserted, drive the hold encoding, so a reset in RUN abandons any branch, push or pop in flight.

Configuration
REQ-030 SHALL compile the return stack in only when macro PC_SEQ_RET_STACK_EN is defined.
REQ-031 SHALL, without PC_SEQ_RET_STACK_EN, treat CALL as JMP and RET as NONE, omit the stack storage, and tie err to 0.

Structure
REQ-032 SHALL take the br_type_t enum, the seq_state_t enum and the BR_* encodings from shared package pc_seq_pkg.
REQ-033 SHALL implement the stack as sub-module ret_stack (push, pop, din, top, full, empty; asynchronous reset).

Verification
REQ-034 SHALL check that after reset, with start=0 for 5 cycles, prog_ctr stays 0 and done=0.
REQ-035 SHALL check that start with NONE instructions gives PC 0,1,2,3, and that stall at PC=3 for 2 cycles keeps PC at 3, then resumes to 4.
REQ-036 SHALL check that BEQ at PC=10 with target_in=0xFFE (-2) and zero_flag=1 gives PC 8, and with zero_flag=0 gives PC 11.
REQ-037 SHALL check that CALL at PC=5 with target_in=0x100, then RET at 0x100, gives PC 0x100 and then 6, with the stack empty afterwards.
REQ-038 SHALL check that 5 nested CALLs with DEPTH=4 make the 5th hold the PC, set err=1, enter HALT and hold done=1; a subsequent reset clears err and done.
REQ-039 SHALL check that halt_req at PC=20 gives done=1 next cycle and PC frozen at 20 indefinitely.
